// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: sequences one convolution job at a time.
// Flow: load filter words, load tagged IF words, pulse start, drain results, pulse done.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   job_valid/job_ready           job handshake; job_*_cnt captured on accept
//   src_filt_* / src_if_*         filter and IF word sources (valid/ready)
//   filter_wen/din/full           filter FIFO write port
//   if_wen/din/full               IF FIFO write port; din[IF_W+1]=first tag, din[IF_W]=last tag
//   start                         one-cycle datapath launch pulse
//   outbuf_ren/dout/empty         first-word-fall-through output FIFO read port
//   res_valid/data/ready          result sink
//   busy, done, err               status: busy when not idle, done pulse, sticky error
//
// Optional feature: define SEQ_TIMEOUT_EN to enable a DRAIN watchdog of TIMEOUT cycles
// that sets err and finishes the job. Without it err is tied to 0.
//
// Handshake strobes and data outputs are decoded combinationally from the
// registered state so that the source/sink handshakes add no latency.
module conv_job_sequencer #(
    parameter int unsigned IF_W    = 8,
    parameter int unsigned FILT_W  = 8,
    parameter int unsigned OUT_W   = 17,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [CNT_W-1:0]  job_filt_cnt,
    input  logic [CNT_W-1:0]  job_if_cnt,
    input  logic [CNT_W-1:0]  job_out_cnt,
    input  logic              src_filt_valid,
    input  logic [FILT_W-1:0] src_filt_data,
    output logic              src_filt_ready,
    input  logic              src_if_valid,
    input  logic [IF_W-1:0]   src_if_data,
    output logic              src_if_ready,
    output logic              filter_wen,
    output logic [FILT_W-1:0] filter_din,
    input  logic              filter_full,
    output logic              if_wen,
    output logic [IF_W+1:0]   if_din,
    input  logic              if_full,
    output logic              start,
    output logic              outbuf_ren,
    input  logic [OUT_W-1:0]  outbuf_dout,
    input  logic              outbuf_empty,
    output logic              res_valid,
    output logic [OUT_W-1:0]  res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FILT,
        S_LOAD_IF,
        S_KICK,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic [CNT_W-1:0] if_cnt_q, if_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] cnt_inc;

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic            err_q, err_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 32'd0);
`endif

    // One shared phase counter; it restarts at 0 on every phase change.
    assign cnt_inc = cnt_q + CNT_W'(1);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            filt_cnt_q <= '0;
            if_cnt_q   <= '0;
            out_cnt_q  <= '0;
`ifdef SEQ_TIMEOUT_EN
            err_q      <= 1'b0;
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            filt_cnt_q <= filt_cnt_d;
            if_cnt_q   <= if_cnt_d;
            out_cnt_q  <= out_cnt_d;
`ifdef SEQ_TIMEOUT_EN
            err_q      <= err_d;
            wdog_q     <= wdog_d;
`endif
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        filt_cnt_d     = filt_cnt_q;
        if_cnt_d       = if_cnt_q;
        out_cnt_d      = out_cnt_q;
`ifdef SEQ_TIMEOUT_EN
        err_d          = err_q;
        wdog_d         = '0;
        err            = err_q;
`else
        err            = 1'b0;
`endif
        job_ready      = 1'b0;
        src_filt_ready = 1'b0;
        src_if_ready   = 1'b0;
        filter_wen     = 1'b0;
        filter_din     = '0;
        if_wen         = 1'b0;
        if_din         = '0;
        start          = 1'b0;
        outbuf_ren     = 1'b0;
        res_valid      = 1'b0;
        res_data       = '0;
        done           = 1'b0;
        busy           = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    filt_cnt_d = job_filt_cnt;
                    if_cnt_d   = job_if_cnt;
                    out_cnt_d  = job_out_cnt;
                    cnt_d      = '0;
`ifdef SEQ_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                    if (job_filt_cnt != '0) begin
                        state_d = S_LOAD_FILT;
                    end else if (job_if_cnt != '0) begin
                        state_d = S_LOAD_IF;
                    end else begin
                        state_d = S_KICK;
                    end
                end
            end

            S_LOAD_FILT: begin
                src_filt_ready = ~filter_full;
                filter_wen     = src_filt_valid & ~filter_full;
                filter_din     = src_filt_data;
                if (filter_wen) begin
                    if (cnt_inc == filt_cnt_q) begin
                        cnt_d   = '0;
                        state_d = (if_cnt_q != '0) ? S_LOAD_IF : S_KICK;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_LOAD_IF: begin
                src_if_ready = ~if_full;
                if_wen       = src_if_valid & ~if_full;
                // Tags: first on index 0, last on index count-1 (both for a 1-word job).
                if_din       = {(cnt_q == '0), (cnt_inc == if_cnt_q), src_if_data};
                if (if_wen) begin
                    if (cnt_inc == if_cnt_q) begin
                        cnt_d   = '0;
                        state_d = S_KICK;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            S_KICK: begin
                start   = 1'b1;
                state_d = (out_cnt_q != '0) ? S_DRAIN : S_DONE;
            end

            S_DRAIN: begin
                res_valid  = ~outbuf_empty;
                res_data   = outbuf_dout;
                outbuf_ren = res_valid & res_ready;
                if (outbuf_ren) begin
                    if (cnt_inc == out_cnt_q) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`ifdef SEQ_TIMEOUT_EN
                // Watchdog restarts on every transfer; expiry abandons the drain.
                else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
`endif
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
